// File: rtl/mem_responder.sv
// Single-request memory responder: big-endian byte array with word/half/byte access, fault detection and programmable wait states.
// Latency WAIT_CYCLES+1 edges from acceptance to response strobe; req_ready stays low from acceptance until RESP exits, and responses cannot be backpressured.
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] fault_addr
);
    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q, fault_addr_q;
    logic        fault_q;
    logic [7:0]  mem_q [DEPTH];

    logic        accept, enter_resp, in_idle;
    logic        cur_wr;
    logic [1:0]  cur_size;
    logic [31:0] cur_addr, cur_wdata;
    logic        fault;
    logic [ADDR_W-1:0] idx0, idx1, idx2, idx3;
    logic [31:0] read_val;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states the response is committed on the acceptance edge,
    // so the live request must be used instead of the captured copy.
    assign in_idle   = (state_q == S_IDLE);
    assign cur_wr    = in_idle ? req_wr    : wr_q;
    assign cur_size  = in_idle ? req_size  : size_q;
    assign cur_addr  = in_idle ? req_addr  : addr_q;
    assign cur_wdata = in_idle ? req_wdata : wdata_q;

    assign fault = (cur_size == 2'b11)
                || ((cur_size == 2'b00) && (cur_addr[1:0] != 2'b00))
                || ((cur_size == 2'b01) && cur_addr[0])
                || ((cur_addr >> ADDR_W) != 32'd0);

    assign idx0 = cur_addr[ADDR_W-1:0];
    assign idx1 = {idx0[ADDR_W-1:1], 1'b1};
    assign idx2 = {idx0[ADDR_W-1:2], 2'b10};
    assign idx3 = {idx0[ADDR_W-1:2], 2'b11};

    always_comb begin
        read_val = 32'd0;
        case (cur_size)
            2'b00:   read_val = {mem_q[idx0], mem_q[idx1], mem_q[idx2], mem_q[idx3]};
            2'b01:   read_val = {16'd0, mem_q[idx0], mem_q[idx1]};
            default: read_val = {24'd0, mem_q[idx0]};
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q         <= 1'b0;
            size_q       <= 2'b00;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            rdata_q      <= 32'd0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'd0;
        end else begin
            if (accept) begin
                wr_q    <= req_wr;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (enter_resp) begin
                fault_q <= fault;
                rdata_q <= (fault || cur_wr) ? 32'd0 : read_val;
                if (fault) fault_addr_q <= cur_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'd0;
        end else if (enter_resp && cur_wr && !fault) begin
            case (cur_size)
                2'b00: begin
                    mem_q[idx0] <= cur_wdata[31:24];
                    mem_q[idx1] <= cur_wdata[23:16];
                    mem_q[idx2] <= cur_wdata[15:8];
                    mem_q[idx3] <= cur_wdata[7:0];
                end
                2'b01: begin
                    mem_q[idx0] <= cur_wdata[15:8];
                    mem_q[idx1] <= cur_wdata[7:0];
                end
                default: mem_q[idx0] <= cur_wdata[7:0];
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_fault = fault_q;
    assign fault_addr = fault_addr_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (1, 3 and 0 wait states) checked against a byte-array model.
module tb_mem_responder;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n      [3];
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_wr     [3];
    logic [1:0]  req_size   [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic        resp_valid [3];
    logic [31:0] resp_rdata [3];
    logic        resp_fault [3];
    logic [31:0] fault_addr [3];

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .reset(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_wr(req_wr[0]), .req_size(req_size[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_fault(resp_fault[0]),
        .fault_addr(fault_addr[0]));
    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .reset(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_wr(req_wr[1]), .req_size(req_size[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_fault(resp_fault[1]),
        .fault_addr(fault_addr[1]));
    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_wr(req_wr[2]), .req_size(req_size[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]), .resp_fault(resp_fault[2]),
        .fault_addr(fault_addr[2]));

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mdl [3][DEPTH];
    logic [31:0] mfa [3];

    function automatic int wc(input int d);
        return (d == 0) ? 1 : (d == 1) ? 3 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input int d);
        for (int i = 0; i < DEPTH; i++) mdl[d][i] = 8'd0;
        mfa[d] = 32'd0;
    endtask

    // Memory as a plain byte array: n bytes, most significant byte at the lowest address.
    task automatic model_op(input int d, input logic wr, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] erd, output logic ef);
        int nb;
        nb  = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
        ef  = (sz == 2'd3) || (sz == 2'd0 && (a % 4) != 0) || (sz == 2'd1 && (a % 2) != 0)
           || (a >= DEPTH);
        erd = 32'd0;
        if (ef) begin
            mfa[d] = a;
        end else if (wr) begin
            for (int b = 0; b < nb; b++) mdl[d][a + b] = 8'((wd >> (8 * (nb - 1 - b))) & 32'hFF);
        end else begin
            for (int b = 0; b < nb; b++) erd = (erd << 8) | 32'(mdl[d][a + b]);
        end
    endtask

    task automatic chk_reset_outputs(input int d, input string tag);
        chk({tag, "_ready"},  32'(req_ready[d]),  32'd1);
        chk({tag, "_rvalid"}, 32'(resp_valid[d]), 32'd0);
        chk({tag, "_rdata"},  resp_rdata[d],      32'd0);
        chk({tag, "_rfault"}, 32'(resp_fault[d]), 32'd0);
        chk({tag, "_faddr"},  fault_addr[d],      32'd0);
    endtask

    // Starts and ends at a falling edge. keep=1 leaves req_valid high and swaps
    // in a different request while the accepted one is in flight.
    task automatic do_req(input int d, input logic wr, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd, input bit keep,
                          input string tag, output logic [31:0] rd_o);
        int w, first, pulses, lowcnt, n;
        logic [31:0] erd, rd_s;
        logic ef, f_s;
        w = wc(d); first = -1; pulses = 0; lowcnt = 0; n = 0;
        rd_s = 32'd0; f_s = 1'b0;
        req_wr[d] = wr; req_size[d] = sz; req_addr[d] = a; req_wdata[d] = wd;
        req_valid[d] = 1'b1;
        while (req_ready[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept"}, 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        model_op(d, wr, sz, a, wd, erd, ef);
        for (int i = 1; i <= w + 2; i++) begin
            @(negedge clk);
            if (i == 1) begin
                if (keep) begin
                    req_wr[d]    = 1'b0;
                    req_wdata[d] = $urandom;
                end else begin
                    req_valid[d] = 1'b0;
                end
            end
            if (resp_valid[d] === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = i;
                    rd_s  = resp_rdata[d];
                    f_s   = resp_fault[d];
                end
            end
            if (req_ready[d] !== 1'b1) lowcnt++;
        end
        chk({tag, "_latency"}, 32'(first),  32'(w + 1));
        chk({tag, "_pulses"},  32'(pulses), 32'd1);
        chk({tag, "_rdylow"},  32'(lowcnt), 32'(w + 1));
        chk({tag, "_rdata"},   rd_s,        erd);
        chk({tag, "_fault"},   32'(f_s),    32'(ef));
        chk({tag, "_faddr"},   fault_addr[d], mfa[d]);
        chk({tag, "_hold"},    resp_rdata[d], rd_s);
        rd_o = rd_s;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd, a, wd;
        logic [1:0]  sz;
        logic        wr;

        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_wr[d] = 1'b0;
            req_size[d] = 2'd0; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
            model_clear(d);
        end
        #1;
        chk_reset_outputs(0, "rst0");
        chk_reset_outputs(1, "rst1");
        chk_reset_outputs(2, "rst2");
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
        @(negedge clk);

        do_req(0, 1'b1, 2'd0, 32'h10, 32'hDEADBEEF, 1'b0, "word_wr", rd);
        chk("word_wr_zero", rd, 32'd0);
        do_req(0, 1'b0, 2'd0, 32'h10, 32'h0, 1'b0, "word_rd", rd);
        chk("word_rd_val", rd, 32'hDEADBEEF);

        do_req(0, 1'b1, 2'd0, 32'h20, 32'h11223344, 1'b0, "mrg_w", rd);
        do_req(0, 1'b1, 2'd2, 32'h21, 32'h000000AA, 1'b0, "mrg_b", rd);
        do_req(0, 1'b1, 2'd1, 32'h22, 32'h0000BBCC, 1'b0, "mrg_h", rd);
        do_req(0, 1'b0, 2'd0, 32'h20, 32'h0, 1'b0, "mrg_rdw", rd);
        chk("mrg_word_val", rd, 32'h11AABBCC);
        do_req(0, 1'b0, 2'd2, 32'h23, 32'h0, 1'b0, "mrg_rdb", rd);
        chk("mrg_byte_val", rd, 32'h000000CC);

        do_req(0, 1'b1, 2'd0, 32'h04, 32'hCAFEF00D, 1'b0, "flt_pre", rd);
        do_req(0, 1'b0, 2'd1, 32'h05, 32'h0, 1'b0, "flt_half", rd);
        chk("flt_half_faddr", fault_addr[0], 32'h05);
        do_req(0, 1'b1, 2'd0, 32'h102, 32'h12345678, 1'b0, "flt_oor_wr", rd);
        do_req(0, 1'b0, 2'd0, 32'h100, 32'h0, 1'b0, "flt_oor_rd", rd);
        do_req(0, 1'b0, 2'd3, 32'h04, 32'h0, 1'b0, "flt_size", rd);
        do_req(0, 1'b0, 2'd0, 32'h04, 32'h0, 1'b0, "flt_post", rd);
        chk("flt_post_val", rd, 32'hCAFEF00D);

        for (int k = 0; k < 40; k++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 32'h10F));
            if ($urandom_range(0, 1) == 1) a = a & ~32'd3;
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            do_req(0, wr, sz, a, wd, 1'b0, "rnd0", rd);
        end

        do_req(1, 1'b1, 2'd0, 32'h40, 32'hA5A55A5A, 1'b1, "hs_wr", rd);
        do_req(1, 1'b0, 2'd0, 32'h40, 32'h0, 1'b0, "hs_rd", rd);
        chk("hs_rd_val", rd, 32'hA5A55A5A);
        for (int k = 0; k < 6; k++) begin
            do_req(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                   32'($urandom_range(0, 32'h3F)) & ~32'd3, $urandom, 1'b1, "rnd1", rd);
        end
        req_valid[1] = 1'b0;

        do_req(2, 1'b1, 2'd0, 32'h80, 32'h01020304, 1'b0, "z_wr", rd);
        for (int k = 0; k < 4; k++) begin
            do_req(2, 1'b0, 2'($urandom_range(0, 2)), 32'h80 + 32'(2 * k), 32'h0, 1'b1, "z_b2b", rd);
        end
        req_valid[2] = 1'b0;
        @(negedge clk);

        req_wr[0] = 1'b1; req_size[0] = 2'd0; req_addr[0] = 32'h08; req_wdata[0] = 32'hFFFFFFFF;
        req_valid[0] = 1'b1;
        chk("ar_pre_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        #2;
        chk("ar_in_wait", 32'(req_ready[0]), 32'd0);
        rst_n[0] = 1'b0;
        req_valid[0] = 1'b0;
        model_clear(0);
        #1;
        chk_reset_outputs(0, "ar");
        @(negedge clk);
        @(negedge clk);
        rst_n[0] = 1'b1;
        @(negedge clk);
        do_req(0, 1'b0, 2'd0, 32'h08, 32'h0, 1'b0, "ar_rd", rd);
        chk("ar_rd_val", rd, 32'd0);
        chk("ar_faddr", fault_addr[0], 32'd0);
        for (int k = 0; k < 8; k++) begin
            do_req(0, 1'b0, 2'd2, 32'($urandom_range(0, DEPTH - 1)), 32'h0, 1'b0, "ar_rnd", rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
